edf_irq_claim: RTL and testbench
================================

# edf_irq_claim

Downstream handshake stage of the EDF interrupt controller. Takes the earliest-deadline candidate ID from the sequential priority queue and presents it to the core as a valid/ID request. On acceptance, it pops the entry from the queue and tracks the interrupt while it is in service. It also measures service time and flags a deadline overrun when service exceeds a configured budget.

## Interface
- NrParIrqs, default 2: number of interrupt sources; must match the priority queue.
- IdWidth, localparam $clog2(NrParIrqs): width of the interrupt ID.
- CntWidth, default 16: width of the service-cycle counter.
- MaxService, default 0: service budget in cycles; 0 disables overrun detection.

Ports:
- clk_i  in  1  sole clock; all logic on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- id_valid_i  in  1  priority queue holds at least one pending candidate.
- id_i  in  IdWidth  current earliest-deadline candidate from the queue.
- pop_o  out  1  one-cycle pulse; the queue removes the claimed entry.
- irq_valid_o  out  1  request to the core.
- irq_id_o  out  IdWidth  ID presented to the core.
- irq_ack_i  in  1  core claims the presented ID.
- irq_done_i  in  1  core finished servicing the claimed interrupt.
- busy_o  out  1  an interrupt is in service.
- claimed_id_o  out  IdWidth  ID currently in service.
- svc_cnt_o  out  CntWidth  cycles spent in service for the current claim.
- overrun_o  out  1  sticky flag: current claim exceeded MaxService.

## Operation
- FSM states: IDLE, PRESENT, SERVICE. All outputs are registered.
- IDLE:
  - id_valid_i=1 → PRESENT; irq_valid_o=1 and irq_id_o=id_i from the next cycle.
  - irq_ack_i and irq_done_i are ignored.
- PRESENT, on each cycle:
  - If id_valid_i=1, irq_id_o ← id_i. This lets a newly arrived earlier deadline replace the presented ID before it is claimed.
  - If id_valid_i=0 and no ack: withdraw the request; → IDLE with irq_valid_o=0 next cycle.
  - If irq_ack_i=1: the claim applies to the irq_id_o value visible in that cycle, and it takes precedence over a same-cycle withdraw or ID change. The ID is latched into claimed_id_o; → SERVICE.
- On entry to SERVICE:
  - irq_valid_o=0, busy_o=1, pop_o=1 for exactly one cycle.
  - svc_cnt_o=0, overrun_o=0.
- SERVICE:
  - svc_cnt_o increments by 1 per cycle and saturates at 2^CntWidth-1.
  - If MaxService≠0 and svc_cnt_o reaches MaxService, overrun_o is set and held until the next claim.
  - irq_ack_i is ignored. id_valid_i/id_i changes are ignored; there is no nesting or preemption of an in-service interrupt.
  - irq_done_i=1 → IDLE. busy_o=0 next cycle. claimed_id_o, svc_cnt_o and overrun_o hold their last values until the next claim.
- Only one pop_o is issued per ack; an ID is never claimed twice without a new presentation.

## Timing
- Reset values: state IDLE, and pop_o, irq_valid_o, irq_id_o, busy_o, claimed_id_o, svc_cnt_o, overrun_o all 0.
- Reset asserted mid-operation clears everything immediately, with no pop_o. An in-flight claim is lost.
- Presentation latency: id_valid_i rising at edge t gives irq_valid_o=1 after edge t+1.
- Ack at cycle t:
  - pop_o=1, busy_o=1 and irq_valid_o=0 in cycle t+1.
  - pop_o=0 from cycle t+2.
  - svc_cnt_o=1 in cycle t+2.
- irq_done_i in cycle t: IDLE in t+1. The earliest new irq_valid_o is in t+2, giving the queue one cycle to settle after the pop.
- irq_done_i and irq_ack_i in the same cycle while in SERVICE: done is honoured, ack is ignored.
- Counter saturation: svc_cnt_o never wraps.
- MaxService ≥ 2^CntWidth: overrun never fires.

## Test plan
- Reset, then id_valid_i=1, id_i=1 → irq_valid_o=1, irq_id_o=1 one cycle later. Hold the request; ack → pop_o high exactly one cycle, busy_o=1, claimed_id_o=1.
- PRESENT with id_i changing 1→0 before ack; ack in the cycle irq_id_o=0 → claimed_id_o=0 and a single pop_o.
- id_valid_i drops while in PRESENT with no ack → irq_valid_o=0 next cycle, no pop_o, state IDLE. Then ack and withdraw in the same cycle → claim taken.
- MaxService=5: ack, hold done low for 8 cycles → overrun_o=1 when svc_cnt_o=5, svc_cnt_o=8 at done. Next claim clears overrun_o and svc_cnt_o.
- CntWidth=3, MaxService=0: service for 12 cycles → svc_cnt_o saturates at 7, overrun_o stays 0.
- Assert rst_i during SERVICE and during PRESENT → all outputs 0 immediately, no pop_o. After release with id_valid_i=1, presentation resumes one cycle later.

Source files
------------

// File: rtl/edf_irq_claim_if.sv
// Handshake bundle between the priority queue, the claim stage and the core.
// Signal names are seen from the claim stage: _i enters it, _o leaves it.
interface edf_irq_claim_if #(
    parameter int unsigned IdWidth = 1
);
    logic               id_valid_i;
    logic [IdWidth-1:0] id_i;
    logic               pop_o;
    logic               irq_valid_o;
    logic [IdWidth-1:0] irq_id_o;
    logic               irq_ack_i;
    logic               irq_done_i;

    // Claim stage side.
    modport slave (
        input  id_valid_i, id_i, irq_ack_i, irq_done_i,
        output pop_o, irq_valid_o, irq_id_o
    );

    // Queue/core side (drives the request inputs, observes the outputs).
    modport master (
        output id_valid_i, id_i, irq_ack_i, irq_done_i,
        input  pop_o, irq_valid_o, irq_id_o
    );
endinterface

// File: rtl/edf_irq_claim.sv
// EDF interrupt claim stage: presents the earliest-deadline candidate to the
// core, pops it from the queue on ack, and times the service interval with an
// optional overrun budget. All outputs are registered.
module edf_irq_claim #(
    parameter int unsigned NrParIrqs  = 2,
    parameter int unsigned CntWidth   = 16,
    parameter int unsigned MaxService = 0,
    localparam int unsigned IdWidth   = (NrParIrqs > 1) ? $clog2(NrParIrqs) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    edf_irq_claim_if.slave      bus_if,
    output logic                busy_o,
    output logic [IdWidth-1:0]  claimed_id_o,
    output logic [CntWidth-1:0] svc_cnt_o,
    output logic                overrun_o
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StPresent = 2'd1;
    localparam logic [1:0] StService = 2'd2;

    logic [1:0]          state_q, state_d;
    logic                pop_q, pop_d;
    logic                irq_valid_q, irq_valid_d;
    logic [IdWidth-1:0]  irq_id_q, irq_id_d;
    logic                busy_q, busy_d;
    logic [IdWidth-1:0]  claimed_id_q, claimed_id_d;
    logic [CntWidth-1:0] svc_cnt_q, svc_cnt_d;
    logic                overrun_q, overrun_d;
    logic [CntWidth-1:0] svc_cnt_inc;

    // Saturating increment; the counter never wraps.
    assign svc_cnt_inc = (svc_cnt_q == {CntWidth{1'b1}}) ? svc_cnt_q
                                                         : svc_cnt_q + CntWidth'(1);

    // Next-state logic for the claim FSM and all registered outputs.
    always_comb begin
        state_d      = state_q;
        pop_d        = 1'b0;
        irq_valid_d  = irq_valid_q;
        irq_id_d     = irq_id_q;
        busy_d       = busy_q;
        claimed_id_d = claimed_id_q;
        svc_cnt_d    = svc_cnt_q;
        overrun_d    = overrun_q;

        case (state_q)
            StIdle: begin
                if (bus_if.id_valid_i) begin
                    state_d     = StPresent;
                    irq_valid_d = 1'b1;
                    irq_id_d    = bus_if.id_i;
                end
            end
            StPresent: begin
                if (bus_if.irq_ack_i) begin
                    // Claim binds to the ID the core saw this cycle, even if the
                    // queue withdraws or reorders in the same cycle.
                    state_d      = StService;
                    irq_valid_d  = 1'b0;
                    pop_d        = 1'b1;
                    busy_d       = 1'b1;
                    claimed_id_d = irq_id_q;
                    svc_cnt_d    = '0;
                    overrun_d    = 1'b0;
                end else if (bus_if.id_valid_i) begin
                    irq_id_d = bus_if.id_i;
                end else begin
                    state_d     = StIdle;
                    irq_valid_d = 1'b0;
                end
            end
            StService: begin
                if (bus_if.irq_done_i) begin
                    // Counter and overrun keep their final values for inspection.
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else begin
                    svc_cnt_d = svc_cnt_inc;
                    // Compared in 32 bits so a budget beyond the counter range
                    // can never match.
                    if (MaxService != 0 && 32'(svc_cnt_inc) == MaxService) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = StIdle;
                irq_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            pop_q        <= 1'b0;
            irq_valid_q  <= 1'b0;
            irq_id_q     <= '0;
            busy_q       <= 1'b0;
            claimed_id_q <= '0;
            svc_cnt_q    <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pop_q        <= pop_d;
            irq_valid_q  <= irq_valid_d;
            irq_id_q     <= irq_id_d;
            busy_q       <= busy_d;
            claimed_id_q <= claimed_id_d;
            svc_cnt_q    <= svc_cnt_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus_if.pop_o       = pop_q;
    assign bus_if.irq_valid_o = irq_valid_q;
    assign bus_if.irq_id_o    = irq_id_q;
    assign busy_o             = busy_q;
    assign claimed_id_o       = claimed_id_q;
    assign svc_cnt_o          = svc_cnt_q;
    assign overrun_o          = overrun_q;

endmodule

// File: tb/tb_edf_irq_claim.sv
// Directed bench for edf_irq_claim. Two instances share one stimulus stream:
// dut_a has a 16-bit counter with a 5-cycle budget, dut_b a 3-bit counter with
// overrun detection disabled.
module tb_edf_irq_claim;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    int n_checks = 0;
    int n_fails  = 0;

    edf_irq_claim_if #(.IdWidth(1)) if_a ();
    edf_irq_claim_if #(.IdWidth(1)) if_b ();

    logic        busy_a, busy_b;
    logic [0:0]  claimed_a, claimed_b;
    logic [15:0] cnt_a;
    logic [2:0]  cnt_b;
    logic        ovr_a, ovr_b;

    assign if_b.id_valid_i = if_a.id_valid_i;
    assign if_b.id_i       = if_a.id_i;
    assign if_b.irq_ack_i  = if_a.irq_ack_i;
    assign if_b.irq_done_i = if_a.irq_done_i;

    edf_irq_claim #(.NrParIrqs(2), .CntWidth(16), .MaxService(5)) dut_a (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bus_if       (if_a),
        .busy_o       (busy_a),
        .claimed_id_o (claimed_a),
        .svc_cnt_o    (cnt_a),
        .overrun_o    (ovr_a)
    );

    edf_irq_claim #(.NrParIrqs(2), .CntWidth(3), .MaxService(0)) dut_b (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bus_if       (if_b),
        .busy_o       (busy_b),
        .claimed_id_o (claimed_b),
        .svc_cnt_o    (cnt_b),
        .overrun_o    (ovr_b)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".pop"},     32'(if_a.pop_o), 0);
        check({tag, ".valid"},   32'(if_a.irq_valid_o), 0);
        check({tag, ".id"},      32'(if_a.irq_id_o), 0);
        check({tag, ".busy"},    32'(busy_a), 0);
        check({tag, ".claimed"}, 32'(claimed_a), 0);
        check({tag, ".cnt"},     32'(cnt_a), 0);
        check({tag, ".ovr"},     32'(ovr_a), 0);
    endtask

    initial begin
        if_a.id_valid_i = 1'b0;
        if_a.id_i       = 1'b0;
        if_a.irq_ack_i  = 1'b0;
        if_a.irq_done_i = 1'b0;

        // Reset state.
        cyc();
        cyc();
        check_idle_outputs("reset");
        rst_i = 1'b0;

        // Basic presentation and claim of ID 1.
        if_a.id_valid_i = 1'b1;
        if_a.id_i       = 1'b1;
        cyc();
        check("t1.valid", 32'(if_a.irq_valid_o), 1);
        check("t1.id", 32'(if_a.irq_id_o), 1);
        check("t1.pop_pre", 32'(if_a.pop_o), 0);
        if_a.irq_ack_i = 1'b1;
        cyc();
        check("t1.pop", 32'(if_a.pop_o), 1);
        check("t1.busy", 32'(busy_a), 1);
        check("t1.valid_off", 32'(if_a.irq_valid_o), 0);
        check("t1.claimed", 32'(claimed_a), 1);
        check("t1.cnt0", 32'(cnt_a), 0);
        if_a.irq_ack_i  = 1'b0;
        if_a.id_valid_i = 1'b0;
        cyc();
        check("t1.pop_once", 32'(if_a.pop_o), 0);
        check("t1.cnt1", 32'(cnt_a), 1);
        if_a.irq_done_i = 1'b1;
        cyc();
        check("t1.done_busy", 32'(busy_a), 0);
        check("t1.done_cnt", 32'(cnt_a), 1);
        check("t1.done_claimed", 32'(claimed_a), 1);
        if_a.irq_done_i = 1'b0;

        // ID replaced 1 -> 0 before the ack.
        if_a.id_valid_i = 1'b1;
        if_a.id_i       = 1'b1;
        cyc();
        check("t2.id1", 32'(if_a.irq_id_o), 1);
        if_a.id_i = 1'b0;
        cyc();
        check("t2.id0", 32'(if_a.irq_id_o), 0);
        check("t2.valid", 32'(if_a.irq_valid_o), 1);
        if_a.irq_ack_i = 1'b1;
        cyc();
        check("t2.claimed", 32'(claimed_a), 0);
        check("t2.pop", 32'(if_a.pop_o), 1);
        if_a.irq_ack_i  = 1'b0;
        if_a.id_valid_i = 1'b0;
        cyc();
        check("t2.pop_once", 32'(if_a.pop_o), 0);
        cyc();
        check("t2.pop_still0", 32'(if_a.pop_o), 0);
        if_a.irq_done_i = 1'b1;
        cyc();
        if_a.irq_done_i = 1'b0;

        // Withdraw without ack.
        if_a.id_valid_i = 1'b1;
        if_a.id_i       = 1'b1;
        cyc();
        check("t3.valid", 32'(if_a.irq_valid_o), 1);
        if_a.id_valid_i = 1'b0;
        cyc();
        check("t3.withdraw", 32'(if_a.irq_valid_o), 0);
        check("t3.no_pop", 32'(if_a.pop_o), 0);
        check("t3.no_busy", 32'(busy_a), 0);
        cyc();
        check("t3.stay_idle", 32'(if_a.irq_valid_o), 0);

        // Ack and withdraw in the same cycle: the claim wins.
        if_a.id_valid_i = 1'b1;
        if_a.id_i       = 1'b0;
        cyc();
        check("t4.valid", 32'(if_a.irq_valid_o), 1);
        if_a.id_valid_i = 1'b0;
        if_a.irq_ack_i  = 1'b1;
        cyc();
        check("t4.pop", 32'(if_a.pop_o), 1);
        check("t4.busy", 32'(busy_a), 1);
        check("t4.claimed", 32'(claimed_a), 0);
        if_a.irq_ack_i = 1'b0;

        // Overrun at 5 on dut_a; dut_b saturates at 7 along the way.
        for (int i = 1; i <= 4; i++) cyc();
        check("t5.cnt4", 32'(cnt_a), 4);
        check("t5.ovr_pre", 32'(ovr_a), 0);
        cyc();
        check("t5.cnt5", 32'(cnt_a), 5);
        check("t5.ovr_set", 32'(ovr_a), 1);
        for (int i = 6; i <= 8; i++) cyc();
        check("t5.cnt8", 32'(cnt_a), 8);
        check("t5.ovr_held", 32'(ovr_a), 1);
        check("t5.b_sat", 32'(cnt_b), 7);
        if_a.irq_done_i = 1'b1;
        cyc();
        if_a.irq_done_i = 1'b0;
        check("t5.done_cnt", 32'(cnt_a), 8);
        check("t5.done_ovr", 32'(ovr_a), 1);
        check("t5.done_busy", 32'(busy_a), 0);

        // Next claim clears the counter and overrun; then a 12-cycle service.
        if_a.id_valid_i = 1'b1;
        if_a.id_i       = 1'b1;
        cyc();
        if_a.irq_ack_i  = 1'b1;
        if_a.id_valid_i = 1'b0;
        cyc();
        check("t6.cnt_clr", 32'(cnt_a), 0);
        check("t6.ovr_clr", 32'(ovr_a), 0);
        check("t6.b_cnt_clr", 32'(cnt_b), 0);
        if_a.irq_ack_i = 1'b0;
        for (int i = 0; i < 12; i++) cyc();
        check("t6.cnt12", 32'(cnt_a), 12);
        check("t6.ovr", 32'(ovr_a), 1);
        check("t6.b_sat", 32'(cnt_b), 7);
        check("t6.b_no_ovr", 32'(ovr_b), 0);

        // Done and ack together in service: done wins, no new claim.
        if_a.irq_done_i = 1'b1;
        if_a.irq_ack_i  = 1'b1;
        cyc();
        check("t7.busy", 32'(busy_a), 0);
        check("t7.pop", 32'(if_a.pop_o), 0);
        check("t7.b_hold", 32'(cnt_b), 7);
        if_a.irq_done_i = 1'b0;
        if_a.irq_ack_i  = 1'b0;
        cyc();
        check("t7.idle_valid", 32'(if_a.irq_valid_o), 0);
        check("t7.idle_busy", 32'(busy_a), 0);

        // Reset during SERVICE.
        if_a.id_valid_i = 1'b1;
        if_a.id_i       = 1'b1;
        cyc();
        if_a.irq_ack_i = 1'b1;
        cyc();
        check("t8.pop", 32'(if_a.pop_o), 1);
        if_a.irq_ack_i = 1'b0;
        cyc();
        check("t8.busy", 32'(busy_a), 1);
        rst_i = 1'b1;
        #1;
        check_idle_outputs("t8.rst_svc");
        cyc();
        check("t8.rst_no_pop", 32'(if_a.pop_o), 0);
        rst_i = 1'b0;
        cyc();
        check("t8.resume_valid", 32'(if_a.irq_valid_o), 1);
        check("t8.resume_id", 32'(if_a.irq_id_o), 1);

        // Reset during PRESENT.
        rst_i = 1'b1;
        #1;
        check_idle_outputs("t9.rst_pres");
        if_a.id_valid_i = 1'b0;
        cyc();
        rst_i = 1'b0;
        cyc();
        check("t9.idle", 32'(if_a.irq_valid_o), 0);
        if_a.id_valid_i = 1'b1;
        cyc();
        check("t9.resume_valid", 32'(if_a.irq_valid_o), 1);
        check("t9.no_pop", 32'(if_a.pop_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
